// File: rtl/button_io_pkg.sv
// Shared types and helpers for the button event queue.
package button_io_pkg;

  localparam int unsigned N_BUTTONS_MAX = 8;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic       press;
    logic [2:0] idx;
  } btn_evt_t;

endpackage

// File: rtl/button_event_queue_if.sv
// Valid/ready event stream with FIFO occupancy, from the queue to its consumer.
interface button_event_queue_if #(
  parameter int unsigned N_BUTTONS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  import button_io_pkg::*;

  localparam int unsigned IdxW = idx_w(N_BUTTONS);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            evt_valid;
  logic            evt_ready;
  logic [IdxW:0]   evt_data;
  logic [CntW-1:0] evt_count;

  modport master (output evt_valid, output evt_data, output evt_count, input evt_ready);
  modport slave  (input evt_valid, input evt_data, input evt_count, output evt_ready);

endinterface

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, debounce counter, committed level and pending-event flag.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic ack_i,
  output logic stable_o,
  output logic pending_o
);

  logic       s1_q, s2_q;
  logic       stable_q, stable_d;
  logic       pending_q, pending_d;
  logic [7:0] cnt_q, cnt_d;

  // A pending event blocks further commits so no edge is lost.
  always_comb begin
    stable_d  = stable_q;
    pending_d = pending_q && !ack_i;
    cnt_d     = '0;
    if ((s2_q == stable_q) || pending_q) begin
      cnt_d = '0;
    end else if (({1'b0, cnt_q} + 9'd1) == 9'(DEBOUNCE_CYCLES)) begin
      stable_d  = s2_q;
      pending_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      stable_q  <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign stable_o  = stable_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/button_event_queue.sv
// Debounced button press/release events into a small FIFO, plus the LED register.
module button_event_queue
  import button_io_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_BUTTONS-1:0] buttons,
  button_event_queue_if.master evt,
  input  logic                 led_we,
  input  logic [N_BUTTONS-1:0] led_wdata,
  input  logic [N_BUTTONS-1:0] led_toggle,
  output logic [N_BUTTONS-1:0] leds
);

  localparam int unsigned IdxW = idx_w(N_BUTTONS);
  localparam int unsigned PtrW = idx_w(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [N_BUTTONS-1:0] stable, pending, ack;
  logic                 push_req, push, pop, full;
  logic [IdxW-1:0]      arb_idx;
  btn_evt_t             push_evt;
  logic [IdxW:0]        fifo_wdata;

  logic [IdxW:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntW-1:0]      count_q, count_d;
  logic [N_BUTTONS-1:0] leds_q, leds_d;

  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_deb
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_i     (buttons[g]),
      .ack_i     (ack[g]),
      .stable_o  (stable[g]),
      .pending_o (pending[g])
    );
  end

  // Lowest-index pending button wins; scan downward so the last hit is the lowest.
  always_comb begin
    push_req = 1'b0;
    arb_idx  = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        push_req = 1'b1;
        arb_idx  = IdxW'(i);
      end
    end
  end

  // Full is taken from the registered count, so a same-cycle pop never frees a slot.
  assign full = (count_q == CntW'(FIFO_DEPTH));
  assign push = push_req && !full;
  assign pop  = (count_q != '0) && evt.evt_ready;

  always_comb begin
    ack = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      ack[i] = push && (arb_idx == IdxW'(i));
    end
  end

  always_comb begin
    push_evt.press = stable[arb_idx];
    push_evt.idx   = 3'(arb_idx);
    fifo_wdata     = {push_evt.press, push_evt.idx[IdxW-1:0]};
    count_d        = count_q + CntW'(push) - CntW'(pop);
    leds_d         = (led_we ? led_wdata : leds_q) ^ led_toggle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      leds_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= fifo_wdata;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      count_q <= count_d;
      leds_q  <= leds_d;
    end
  end

  assign evt.evt_valid = (count_q != '0);
  assign evt.evt_data  = mem_q[rptr_q];
  assign evt.evt_count = count_q;
  assign leds          = leds_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed and randomized checks of button_event_queue against an event-level model.
module tb_button_event_queue;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] buttons;
  logic       led_we;
  logic [7:0] led_wdata, led_toggle, leds;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ready_mode = 0;  // 0: never ready, 1: always ready, 2: random

  logic [3:0] got_q [$];
  int         got_rd = 0;
  logic [3:0] exp_q [$];

  button_event_queue_if #(.N_BUTTONS(8), .FIFO_DEPTH(4)) evt_if ();

  button_event_queue #(
    .N_BUTTONS       (8),
    .DEBOUNCE_CYCLES (D),
    .FIFO_DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .buttons    (buttons),
    .evt        (evt_if),
    .led_we     (led_we),
    .led_wdata  (led_wdata),
    .led_toggle (led_toggle),
    .leds       (leds)
  );

  always #5 clk = ~clk;

  // Consumer: ready is chosen on the falling edge; a head seen with ready high pops next edge.
  always @(negedge clk) begin
    logic rdy;
    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    evt_if.evt_ready = rdy;
    if (rst_n && evt_if.evt_valid && rdy) got_q.push_back(evt_if.evt_data);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_evt(input logic press, input int idx);
    exp_q.push_back({press, 3'(idx)});
  endfunction

  // Wait, then compare everything consumed so far against the expected event list.
  task automatic settle(input string tag, input int n);
    int got_n;
    tick(n);
    got_n = got_q.size() - got_rd;
    chk({tag, "_num"}, 32'(got_n), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      chk({tag, "_evt"}, 32'(got_q[got_rd]), 32'(exp_q[0]));
      got_rd++;
      void'(exp_q.pop_front());
    end
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  initial begin
    logic [7:0] level, mask, leds_m;
    int         len;

    rst_n      = 1'b0;
    buttons    = 8'h00;
    led_we     = 1'b0;
    led_wdata  = 8'h00;
    led_toggle = 8'h00;
    evt_if.evt_ready = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_count", 32'(evt_if.evt_count), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    tick(50);
    chk("idle_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("idle_count", 32'(evt_if.evt_count), 32'd0);
    chk("idle_leds", 32'(leds), 32'd0);

    // Single press: valid must rise exactly D+2 edges after capture.
    buttons[3] = 1'b1;
    tick(D + 2);
    chk("b3_early", 32'(evt_if.evt_valid), 32'd0);
    tick(1);
    chk("b3_valid", 32'(evt_if.evt_valid), 32'd1);
    chk("b3_data", 32'(evt_if.evt_data), 32'hB);
    chk("b3_count", 32'(evt_if.evt_count), 32'd1);
    tick(5);
    chk("b3_hold", 32'(evt_if.evt_data), 32'hB);
    ready_mode = 1;
    expect_evt(1'b1, 3);
    settle("b3_press", 5);
    buttons[3] = 1'b0;
    expect_evt(1'b0, 3);
    settle("b3_rel", 20);

    // Glitch just short of the debounce length, then one exactly long enough.
    buttons[5] = 1'b1;
    tick(D - 1);
    buttons[5] = 1'b0;
    settle("b5_glitch", 20);
    buttons[5] = 1'b1;
    tick(D);
    buttons[5] = 1'b0;
    expect_evt(1'b1, 5);
    expect_evt(1'b0, 5);
    settle("b5_pulse", 30);

    // All buttons at once with the consumer stalled: FIFO fills with the lowest four.
    ready_mode = 0;
    buttons = 8'hFF;
    tick(25);
    chk("ff_count", 32'(evt_if.evt_count), 32'd4);
    chk("ff_head", 32'(evt_if.evt_data), 32'h8);
    ready_mode = 1;
    for (int i = 0; i < 8; i++) expect_evt(1'b1, i);
    settle("ff_drain", 30);
    chk("ff_empty", 32'(evt_if.evt_count), 32'd0);
    buttons = 8'h00;
    for (int i = 0; i < 8; i++) expect_evt(1'b0, i);
    settle("ff_rel", 40);

    // LED register
    led_we = 1'b1; led_wdata = 8'hA5;
    tick(1);
    chk("led_load", 32'(leds), 32'hA5);
    led_we = 1'b0; led_toggle = 8'h0F;
    tick(1);
    chk("led_tog", 32'(leds), 32'hAA);
    led_we = 1'b1; led_wdata = 8'h00; led_toggle = 8'h81;
    tick(1);
    chk("led_both", 32'(leds), 32'h81);
    led_we = 1'b0; led_toggle = 8'h00;
    tick(1);
    chk("led_hold", 32'(leds), 32'h81);

    // Random phase: each change either reverts before committing or is held long enough.
    ready_mode = 2;
    level  = 8'h00;
    leds_m = leds;
    for (int r = 0; r < 20; r++) begin
      mask = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 2) == 0) begin
        len = $urandom_range(1, D - 1);
        buttons = level ^ mask;
        tick(len);
        buttons = level;
      end else begin
        level   = level ^ mask;
        buttons = level;
        for (int i = 0; i < 8; i++) if (mask[i]) expect_evt(level[i], i);
      end
      led_we     = 1'($urandom_range(0, 1));
      led_wdata  = 8'($urandom);
      led_toggle = 8'($urandom);
      leds_m     = (led_we ? led_wdata : leds_m) ^ led_toggle;
      tick(1);
      led_we = 1'b0; led_toggle = 8'h00;
      chk("rnd_leds", 32'(leds), 32'(leds_m));
      settle("rnd", 80);
    end
    for (int i = 0; i < 8; i++) if (level[i]) expect_evt(1'b0, i);
    buttons = 8'h00;
    settle("rnd_clr", 80);

    // Reset mid-operation with three queued events and a non-zero LED value.
    ready_mode = 0;
    buttons = 8'h07;
    led_we = 1'b1; led_wdata = 8'h3C;
    tick(1);
    led_we = 1'b0;
    tick(25);
    chk("pre_count", 32'(evt_if.evt_count), 32'd3);
    chk("pre_leds", 32'(leds), 32'h3C);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("ar_count", 32'(evt_if.evt_count), 32'd0);
    chk("ar_leds", 32'(leds), 32'd0);
    buttons = 8'h01;
    tick(3);
    rst_n = 1'b1;
    ready_mode = 1;
    expect_evt(1'b1, 0);
    settle("post_rst", 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
